// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - instruction-memory and decode handshake bundle for fetch_sequencer
//
// Purpose: groups the two handshakes of the fetch sequencer.
//   ImemReq/ImemAddr/ImemAck/ImemData : one-outstanding request to instruction memory
//   InstrValid/Instr/InstrPC/DecStall : single-entry output slot towards decode
// Modports:
//   master : the fetch sequencer (drives request and decode slot)
//   slave  : memory/decode side (drives ack, data and stall)
interface fetch_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic              ImemReq;
  logic [ADDR_W-1:0] ImemAddr;
  logic              ImemAck;
  logic [31:0]       ImemData;
  logic              InstrValid;
  logic [31:0]       Instr;
  logic [ADDR_W-3:0] InstrPC;
  logic              DecStall;

  modport master (
    output ImemReq, ImemAddr, InstrValid, Instr, InstrPC,
    input  ImemAck, ImemData, DecStall
  );

  modport slave (
    input  ImemReq, ImemAddr, InstrValid, Instr, InstrPC,
    output ImemAck, ImemData, DecStall
  );
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - single-outstanding instruction fetch sequencer with redirect handling
//
// Purpose: walks a word-address PC, issues one instruction-memory request at a
// time and hands fetched words to decode through a one-entry slot. Control-flow
// redirects (jump, jump-register, taken branch) retarget the PC; a redirect that
// lands while a request is in flight lets that request finish and drops its data.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   Branch, Zero, Jump, JR: control-flow strobes for the instruction at BasePC
//   BasePC                : word address of the control-flow instruction
//   Imm16, TargetInstr    : branch word offset, jump word target
//   Regrs                 : byte-address register value for JR
//   bus (master)          : instruction-memory and decode handshakes
module fetch_sequencer #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(32'h0040_0000)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Branch,
  input  logic                  Zero,
  input  logic                  Jump,
  input  logic                  JR,
  input  logic [ADDR_W-3:0]     BasePC,
  input  logic [15:0]           Imm16,
  input  logic [25:0]           TargetInstr,
  input  logic [ADDR_W-1:0]     Regrs,
  fetch_sequencer_if.master     bus
);

  localparam int PW = ADDR_W - 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [PW-1:0]   pc, pc_n;
  logic [PW-1:0]   tgt, tgt_n;
  logic            valid, valid_n;
  logic [31:0]     instr, instr_n;
  logic [PW-1:0]   instr_pc, instr_pc_n;

  logic            redirect;
  logic            slot_free;
  logic [PW-1:0]   target;
  logic [PW-1:0]   jump_tgt;
  logic [PW-1:0]   branch_tgt;
  logic            unused_bits;

  // Regrs is a byte address; its low two bits never reach the word PC.
  assign unused_bits = ^Regrs[1:0];

  assign redirect  = Jump | (Branch & ~Zero);
  assign slot_free = ~valid | ~bus.DecStall;

  // Pseudo-direct jump keeps the region bits of the jump instruction's PC.
  // At the narrowest width the 26-bit target already spans the whole PC.
  generate
    if (PW > 26) begin : g_jump_wide
      assign jump_tgt = {BasePC[PW-1:26], TargetInstr};
    end else begin : g_jump_narrow
      assign jump_tgt = TargetInstr;
    end
  endgenerate

  // Branch offset is relative to the instruction after the branch; the sum
  // wraps silently modulo the PC width.
  assign branch_tgt = BasePC + PW'(1) + {{(PW-16){Imm16[15]}}, Imm16};

  always_comb begin
    target = branch_tgt;
    if (Jump) begin
      target = JR ? Regrs[ADDR_W-1:2] : jump_tgt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    tgt_n      = tgt;
    valid_n    = valid;
    instr_n    = instr;
    instr_pc_n = instr_pc;

    // Decode consumes the slot; a fill in the same cycle below overrides this.
    if (valid && !bus.DecStall) begin
      valid_n = 1'b0;
    end

    case (state)
      IDLE: begin
        if (redirect) begin
          // Whatever sits in the slot is on the wrong path.
          pc_n    = target;
          valid_n = 1'b0;
        end else if (slot_free) begin
          state_n = BUSY;
        end
      end

      BUSY: begin
        if (bus.ImemAck) begin
          if (redirect) begin
            pc_n = target;
          end else begin
            instr_n    = bus.ImemData;
            instr_pc_n = pc;
            valid_n    = 1'b1;
            pc_n       = pc + PW'(1);
          end
          state_n = IDLE;
        end else if (redirect) begin
          // PC must keep driving the held address; park the target instead.
          tgt_n   = target;
          state_n = DISCARD;
        end
      end

      DISCARD: begin
        if (bus.ImemAck) begin
          pc_n    = redirect ? target : tgt;
          state_n = IDLE;
        end else if (redirect) begin
          tgt_n = target;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_VEC[ADDR_W-1:2];
      tgt      <= '0;
      valid    <= 1'b0;
      instr    <= '0;
      instr_pc <= '0;
    end else begin
      pc       <= pc_n;
      tgt      <= tgt_n;
      valid    <= valid_n;
      instr    <= instr_n;
      instr_pc <= instr_pc_n;
    end
  end

  assign bus.ImemReq    = (state != IDLE);
  assign bus.ImemAddr   = {pc, 2'b00};
  assign bus.InstrValid = valid;
  assign bus.Instr      = instr;
  assign bus.InstrPC    = instr_pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Branch, Zero, Jump, JR;
  logic [29:0] BasePC;
  logic [15:0] Imm16;
  logic [25:0] TargetInstr;
  logic [31:0] Regrs;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_sequencer_if #(.ADDR_W(32)) fb ();
  fetch_sequencer_if #(.ADDR_W(32)) fb2 ();

  fetch_sequencer #(.ADDR_W(32), .RESET_VEC(32'h0040_0000)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .Branch      (Branch),
    .Zero        (Zero),
    .Jump        (Jump),
    .JR          (JR),
    .BasePC      (BasePC),
    .Imm16       (Imm16),
    .TargetInstr (TargetInstr),
    .Regrs       (Regrs),
    .bus         (fb.master)
  );

  fetch_sequencer #(.ADDR_W(32), .RESET_VEC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk         (clk),
    .rst_n       (rst_n),
    .Branch      (1'b0),
    .Zero        (1'b0),
    .Jump        (1'b0),
    .JR          (1'b0),
    .BasePC      (30'h0),
    .Imm16       (16'h0),
    .TargetInstr (26'h0),
    .Regrs       (32'h0),
    .bus         (fb2.master)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_ctl();
    Branch = 1'b0; Zero = 1'b0; Jump = 1'b0; JR = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_ctl();
    BasePC = '0; Imm16 = '0; TargetInstr = '0; Regrs = '0;
    fb.ImemAck = 1'b0;  fb.ImemData = '0;  fb.DecStall = 1'b0;
    fb2.ImemAck = 1'b0; fb2.ImemData = '0; fb2.DecStall = 1'b0;

    repeat (2) @(negedge clk);
    check_eq("rst_req",   fb.ImemReq, 0);
    check_eq("rst_valid", fb.InstrValid, 0);
    check_eq("rst_instr", fb.Instr, 0);
    check_eq("rst_ipc",   fb.InstrPC, 0);

    // first fetch straight out of reset
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("f0_req",     fb.ImemReq, 1);
    check_eq("f0_addr",    fb.ImemAddr, 32'h0040_0000);
    check_eq("wrap_addr0", fb2.ImemAddr, 32'hFFFF_FFFC);
    fb.ImemAck = 1'b1;  fb.ImemData = 32'h8C01_0004;
    fb2.ImemAck = 1'b1; fb2.ImemData = 32'h0000_0001;
    @(negedge clk);
    fb.ImemAck = 1'b0; fb2.ImemAck = 1'b0;
    check_eq("f0_valid",   fb.InstrValid, 1);
    check_eq("f0_instr",   fb.Instr, 32'h8C01_0004);
    check_eq("f0_ipc",     fb.InstrPC, 30'h0010_0000);
    check_eq("f0_req_low", fb.ImemReq, 0);
    check_eq("wrap_ipc",   fb2.InstrPC, 30'h3FFF_FFFF);

    // decode stall holds the slot and blocks the next request
    fb.DecStall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("stall_req",   fb.ImemReq, 0);
      check_eq("stall_valid", fb.InstrValid, 1);
      check_eq("stall_instr", fb.Instr, 32'h8C01_0004);
    end
    check_eq("wrap_addr1", fb2.ImemAddr, 32'h0000_0000);
    check_eq("wrap_req",   fb2.ImemReq, 1);
    fb.DecStall = 1'b0;
    @(negedge clk);
    check_eq("f1_req",   fb.ImemReq, 1);
    check_eq("f1_addr",  fb.ImemAddr, 32'h0040_0004);
    check_eq("f1_valid", fb.InstrValid, 0);
    fb.ImemAck = 1'b1; fb.ImemData = 32'h1111_1111;
    @(negedge clk);
    fb.ImemAck = 1'b0;
    check_eq("f1_ipc", fb.InstrPC, 30'h0010_0001);

    // branch with Zero=1: no redirect, sequential fetch
    Branch = 1'b1; Zero = 1'b1; BasePC = 30'h0010_0010; Imm16 = 16'hFFFC;
    @(negedge clk);
    clear_ctl();
    check_eq("nt_req",  fb.ImemReq, 1);
    check_eq("nt_addr", fb.ImemAddr, 32'h0040_0008);
    fb.ImemAck = 1'b1; fb.ImemData = 32'h2222_2222;
    @(negedge clk);
    fb.ImemAck = 1'b0;
    check_eq("nt_valid", fb.InstrValid, 1);
    check_eq("nt_instr", fb.Instr, 32'h2222_2222);

    // taken branch in IDLE: flush slot, retarget
    Branch = 1'b1; Zero = 1'b0;
    @(negedge clk);
    clear_ctl();
    check_eq("flush_valid", fb.InstrValid, 0);
    check_eq("flush_req",   fb.ImemReq, 0);
    @(negedge clk);
    check_eq("br_req",  fb.ImemReq, 1);
    check_eq("br_addr", fb.ImemAddr, 32'h0040_0034);

    // JR redirect during BUSY, ack three cycles later
    Jump = 1'b1; JR = 1'b1; Branch = 1'b1; Zero = 1'b0; Regrs = 32'h0040_1000;
    @(negedge clk);
    clear_ctl();
    check_eq("jr_hold0_req",  fb.ImemReq, 1);
    check_eq("jr_hold0_addr", fb.ImemAddr, 32'h0040_0034);
    @(negedge clk);
    check_eq("jr_hold1_addr", fb.ImemAddr, 32'h0040_0034);
    @(negedge clk);
    check_eq("jr_hold2_addr", fb.ImemAddr, 32'h0040_0034);
    fb.ImemAck = 1'b1; fb.ImemData = 32'hDEAD_BEEF;
    @(negedge clk);
    fb.ImemAck = 1'b0;
    check_eq("jr_drop_valid", fb.InstrValid, 0);
    check_eq("jr_drop_req",   fb.ImemReq, 0);
    @(negedge clk);
    check_eq("jr_addr", fb.ImemAddr, 32'h0040_1000);

    // ack and pseudo-direct jump in the same cycle: data dropped
    fb.ImemAck = 1'b1; fb.ImemData = 32'h3333_3333;
    Jump = 1'b1; JR = 1'b0; BasePC = 30'h2000_0000; TargetInstr = 26'h000_0100;
    @(negedge clk);
    clear_ctl();
    fb.ImemAck = 1'b0;
    check_eq("j_drop_valid", fb.InstrValid, 0);
    @(negedge clk);
    check_eq("j_addr", fb.ImemAddr, 32'h8000_0400);

    // two redirects during one held request: the last one wins
    Branch = 1'b1; Zero = 1'b0; BasePC = 30'h0000_0100; Imm16 = 16'h0001;
    @(negedge clk);
    clear_ctl();
    Jump = 1'b1; JR = 1'b1; Regrs = 32'h0000_0800;
    check_eq("d_hold_addr", fb.ImemAddr, 32'h8000_0400);
    @(negedge clk);
    clear_ctl();
    fb.ImemAck = 1'b1; fb.ImemData = 32'h4444_4444;
    @(negedge clk);
    fb.ImemAck = 1'b0;
    check_eq("d_valid", fb.InstrValid, 0);
    @(negedge clk);
    check_eq("d_req",  fb.ImemReq, 1);
    check_eq("d_addr", fb.ImemAddr, 32'h0000_0800);

    // reset asserted mid-BUSY with ack pulsed while low
    rst_n = 1'b0; fb.ImemAck = 1'b1;
    #1;
    check_eq("r_req",   fb.ImemReq, 0);
    check_eq("r_valid", fb.InstrValid, 0);
    check_eq("r_instr", fb.Instr, 0);
    check_eq("r_ipc",   fb.InstrPC, 0);
    @(negedge clk);
    check_eq("r2_req",   fb.ImemReq, 0);
    check_eq("r2_valid", fb.InstrValid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    fb.ImemAck = 1'b0;
    check_eq("rel_valid", fb.InstrValid, 0);
    check_eq("rel_req",   fb.ImemReq, 1);
    check_eq("rel_addr",  fb.ImemAddr, 32'h0040_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width; legal range 28..64.
REQ-002 Parameter RESET_VEC, default 32'h0040_0000, first fetch byte address; bits [1:0] ignored.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Branch, Zero, Jump, JR  in  1 each  control-flow strobes for the instruction at BasePC.
REQ-006 BasePC  in  ADDR_W-2  word address of the control-flow instruction.
REQ-007 Imm16  in  16  branch word offset; TargetInstr  in  26  jump word target.
REQ-008 Regrs  in  ADDR_W  register value for JR.
REQ-009 ImemReq  out  1; ImemAddr  out  ADDR_W; ImemAck  in  1; ImemData  in  32  (instruction memory handshake).
REQ-010 InstrValid  out  1; Instr  out  32; InstrPC  out  ADDR_W-2; DecStall  in  1  (decode handshake).

Function
REQ-011 Redirect SHALL be Jump | (Branch & ~Zero).
REQ-012 Target SHALL be: Jump&JR -> Regrs[ADDR_W-1:2]; Jump&~JR -> {BasePC[ADDR_W-3:26], TargetInstr}; else BasePC + 1 + sign-extended Imm16; Jump has priority over Branch.
REQ-013 All PC arithmetic SHALL be modulo 2^(ADDR_W-2); wrap-around is silent.
REQ-014 States SHALL be IDLE, BUSY, DISCARD; PC is a word-address register.
REQ-015 ImemAddr SHALL equal {PC, 2'b00} whenever ImemReq=1; ImemReq=1 exactly in BUSY and DISCARD.
REQ-016 ImemReq, once high, SHALL stay high with ImemAddr constant until the cycle ImemAck=1; ImemAck with ImemReq=0 is ignored.
REQ-017 IDLE->BUSY when no Redirect and output slot free (InstrValid=0 or DecStall=0); a transfer to decode occurs on InstrValid & ~DecStall and clears InstrValid.
REQ-018 BUSY, ImemAck, no Redirect: Instr<=ImemData, InstrPC<=PC, InstrValid<=1, PC<=PC+1, ->IDLE.
REQ-019 BUSY, no ImemAck, Redirect: PC register for the held request SHALL be preserved for the address; target latched as next PC; ->DISCARD.
REQ-020 BUSY, ImemAck and Redirect same cycle: data dropped, PC<=target, InstrValid stays 0, ->IDLE.
REQ-021 DISCARD: on ImemAck data dropped, PC<=latched target, ->IDLE; further Redirect in DISCARD overwrites latched target (last wins).
REQ-022 IDLE, Redirect: PC<=target, InstrValid<=0 (wrong-path flush), stay IDLE one cycle.
REQ-023 Instr/InstrPC SHALL hold while InstrValid=1 and DecStall=1.
REQ-024 At most one request outstanding; peak throughput one instruction per two cycles.

Reset
REQ-025 rst_n=0 SHALL immediately force state IDLE, PC=RESET_VEC[ADDR_W-1:2], ImemReq=0, InstrValid=0, Instr=0, InstrPC=0, latched target=0.
REQ-026 Reset asserted mid-BUSY SHALL abandon the request; a late ImemAck after release is ignored unless ImemReq=1.
REQ-027 First ImemReq SHALL assert in the first cycle after rst_n deasserts.

Verification (ADDR_W=32, RESET_VEC=0x0040_0000 unless stated)
REQ-028 Release reset, ImemAck 1 cycle after ImemReq, ImemData=0x8C01_0004 -> ImemAddr=0x0040_0000, InstrValid=1, Instr=0x8C01_0004, InstrPC=0x0010_0000, next ImemAddr=0x0040_0004.
REQ-029 DecStall=1 for 3 cycles with InstrValid=1 -> ImemReq=0, Instr held; DecStall=0 -> ImemReq=1 next cycle.
REQ-030 Branch=1, Zero=0, BasePC=0x0010_0010, Imm16=0xFFFC -> next ImemAddr=0x0040_0034; same with Zero=1 -> no redirect.
REQ-031 Jump=JR=1, Branch=1, Zero=0, Regrs=0x0040_1000 in BUSY, ImemAck 3 cycles later -> ImemAddr unchanged until ack, data dropped, InstrValid=0, next ImemAddr=0x0040_1000.
REQ-032 RESET_VEC=0xFFFF_FFFC, one fetch acked -> next ImemAddr=0x0000_0000.
REQ-033 rst_n low during BUSY, ImemAck pulsed while low -> all outputs at reset values; after release ImemAddr=0x0040_0000.
